// File: rtl/fpga_link_arbiter.sv
// Four-requester round-robin arbiter that hands one byte at a time to a link
// transmitter, waits for its end-of-transfer pulse, and aborts on timeout.
module fpga_link_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] reqData,
    input  logic        finishSent,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [3:0]  timeoutErr,
    output logic [7:0]  txData,
    output logic        sent,
    output logic        linkReset,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  ptr_r;
    logic [1:0]  idx_r;
    logic [15:0] cnt_r;
    logic [1:0]  win_s;
    logic [1:0]  cand_s;
    logic        found_s;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: starts just after the last served requester.
    always_comb begin
        win_s   = ptr_r;
        found_s = 1'b0;
        cand_s  = ptr_r;
        for (int k = 1; k <= 4; k++) begin
            cand_s = ptr_r + 2'(k);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic; finishSent only matters while waiting.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: state_s = ST_WAIT;
            ST_WAIT: begin
                if (finishSent) begin
                    state_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_ABORT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ABORT: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register and strobes, registered from the upcoming state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            sent       <= 1'b0;
            busy       <= 1'b0;
            linkReset  <= 1'b0;
            done       <= 4'b0000;
            timeoutErr <= 4'b0000;
        end else begin
            state_r    <= state_s;
            sent       <= (state_s == ST_LOAD);
            busy       <= (state_s != ST_IDLE);
            linkReset  <= (state_s == ST_ABORT);
            done       <= (state_s == ST_DONE)  ? grant : 4'b0000;
            timeoutErr <= (state_s == ST_ABORT) ? grant : 4'b0000;
        end
    end

    // Transfer datapath: grant, captured byte, wait counter, priority pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant  <= 4'b0000;
            txData <= 8'h00;
            idx_r  <= 2'd0;
            cnt_r  <= 16'd0;
            ptr_r  <= 2'd3;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant  <= onehot(win_s);
                        idx_r  <= win_s;
                        txData <= reqData[{win_s, 3'b000} +: 8];
                        cnt_r  <= 16'd0;
                    end else begin
                        grant  <= 4'b0000;
                    end
                end
                ST_LOAD: cnt_r <= 16'd0;
                ST_WAIT: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (state_s != ST_WAIT) begin
                        ptr_r <= idx_r;
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                ST_DONE:  grant <= 4'b0000;
                ST_ABORT: grant <= 4'b0000;
                default:  grant <= 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_link_arbiter.sv
// Directed bench for fpga_link_arbiter built with an 8-cycle timeout.
module tb_fpga_link_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] reqData = 32'h0;
    logic        finishSent = 1'b0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  timeoutErr;
    logic [7:0]  txData;
    logic        sent;
    logic        linkReset;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    fpga_link_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .reqData(reqData),
        .finishSent(finishSent), .grant(grant), .done(done),
        .timeoutErr(timeoutErr), .txData(txData), .sent(sent),
        .linkReset(linkReset), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, {28'd0, grant}, 32'h0);
        chk({tag, "_done"}, {28'd0, done}, 32'h0);
        chk({tag, "_terr"}, {28'd0, timeoutErr}, 32'h0);
        chk({tag, "_txdata"}, {24'd0, txData}, 32'h0);
        chk({tag, "_strobes"}, {29'd0, sent, linkReset, busy}, 32'h0);
    endtask

    logic [3:0] exp_order [4];

    initial begin
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100; exp_order[3] = 4'b1000;

        // Reset state
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'h0);

        // finishSent ignored in IDLE
        finishSent = 1'b1;
        tick();
        chk("idle_fs_ignored", {27'd0, busy, done}, 32'h0);
        finishSent = 1'b0;

        // Single transfer, finishSent in 3rd WAIT cycle
        reqData = 32'h0000_00A5;
        req = 4'b0001;
        tick();
        chk("t1_load_grant", {28'd0, grant}, 32'h1);
        chk("t1_load_txdata", {24'd0, txData}, 32'hA5);
        chk("t1_load_sent_busy", {30'd0, sent, busy}, 32'h3);
        req = 4'b0000;
        tick();
        chk("t1_wait1_sent", {31'd0, sent}, 32'h0);
        chk("t1_wait1_grant", {28'd0, grant}, 32'h1);
        tick();
        chk("t1_wait2_done", {28'd0, done}, 32'h0);
        tick();
        finishSent = 1'b1;
        tick();
        finishSent = 1'b0;
        chk("t1_done", {28'd0, done}, 32'h1);
        chk("t1_done_grant", {28'd0, grant}, 32'h1);
        tick();
        chk("t1_idle_done", {28'd0, done}, 32'h0);
        chk("t1_idle_busy_grant", {27'd0, busy, grant}, 32'h0);

        // Round-robin with all requesting, from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        reqData = 32'h4433_2211;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_grant%0d", i), {28'd0, grant}, {28'd0, exp_order[i]});
            chk($sformatf("rr_txdata%0d", i), {24'd0, txData}, 32'h11 * (i + 1));
            tick();
            finishSent = 1'b1;
            tick();
            finishSent = 1'b0;
            chk($sformatf("rr_done%0d", i), {28'd0, done}, {28'd0, exp_order[i]});
            tick();
        end
        tick();
        chk("rr_grant5", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        tick();
        finishSent = 1'b1;
        tick();
        finishSent = 1'b0;
        tick();

        // Timeout abort on requester 2 (ptr now 0)
        req = 4'b0100;
        tick();
        chk("to_grant", {28'd0, grant}, 32'h4);
        req = 4'b0000;
        for (int w = 1; w <= 8; w++) begin
            tick();
            chk($sformatf("to_wait%0d", w), {26'd0, busy, linkReset, timeoutErr}, 32'h20);
        end
        tick();
        chk("to_terr", {28'd0, timeoutErr}, 32'h4);
        chk("to_linkreset", {31'd0, linkReset}, 32'h1);
        chk("to_done", {28'd0, done}, 32'h0);
        tick();
        chk("to_idle", {25'd0, busy, linkReset, grant, timeoutErr}, 32'h0);
        req = 4'b1111;
        tick();
        chk("to_next_grant", {28'd0, grant}, 32'h8);
        req = 4'b0000;
        tick();
        finishSent = 1'b1;
        tick();
        finishSent = 1'b0;
        chk("to_next_done", {28'd0, done}, 32'h8);
        tick();

        // finishSent on the last WAIT cycle: DONE beats timeout
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int w = 1; w <= 8; w++) tick();
        finishSent = 1'b1;
        tick();
        finishSent = 1'b0;
        chk("edge_done", {28'd0, done}, 32'h1);
        chk("edge_terr", {29'd0, timeoutErr[3:1], linkReset}, 32'h0);
        chk("edge_terr0", {31'd0, timeoutErr[0]}, 32'h0);
        tick();
        chk("edge_idle_terr", {28'd0, timeoutErr}, 32'h0);

        // Byte stays latched and request may drop mid-transfer
        reqData = 32'h0000_003C;
        req = 4'b0001;
        tick();
        chk("hold_load_txdata", {24'd0, txData}, 32'h3C);
        tick();
        reqData = 32'h0000_00FF;
        req = 4'b0000;
        tick();
        chk("hold_wait_txdata", {24'd0, txData}, 32'h3C);
        finishSent = 1'b1;
        tick();
        finishSent = 1'b0;
        chk("hold_done", {28'd0, done}, 32'h1);
        chk("hold_done_txdata", {24'd0, txData}, 32'h3C);
        tick();

        // Asynchronous reset mid-WAIT
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        tick();
        chk("ar_pre_busy", {31'd0, busy}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("ar_async");
        finishSent = 1'b1;
        tick();
        chk("ar_held", {24'd0, done, timeoutErr}, 32'h0);
        reset = 1'b0;
        finishSent = 1'b0;
        tick();
        chk("ar_released", {23'd0, busy, done, timeoutErr}, 32'h0);
        tick();
        chk("ar_released2", {23'd0, busy, done, timeoutErr}, 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
